or1200_vlx_seq: RTL and testbench
=================================

Name: or1200_vlx_seq

Overview:
- Sequencer for the OR1200 VLX (variable-length code) store path in the JPEG encoder.
- Packs each set-bit operation's right-justified code into an MSB-first bit accumulator and emits complete bytes one at a time to the store unit via a store/ack handshake.
- Stalls the CPU until all complete bytes have been written.
- Handles end-of-scan flush with padding and optional JPEG 0xFF byte stuffing; exposes status and a byte counter through SPRs.

Parameters:
- PAD_BIT, 1'b1, value used to pad the final partial byte on flush (JPEG requires 1s).
- CNT_W, 32, width of the emitted-byte counter.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-low reset
- set_bit_op_i  in  1  set-bit instruction in progress
- num_bits_to_write_i  in  5  code length n (0..31)
- bit_vec_i  in  32  code, right-justified in bits [n-1:0]
- ack_i  in  1  store unit has completed the current byte
- byte_o  out  8  byte to store
- store_byte_o  out  1  byte store request
- stall_cpu_o  out  1  CPU stall
- spr_cs  in  1  SPR chip select
- spr_write  in  1  SPR write
- spr_addr  in  2  SPR address
- spr_dat_i  in  32  SPR write data
- spr_dat_o  out  32  SPR read data

Behaviour:
- Reset: rst_i low sampled on rising clk_i (synchronous, active-low).
  - Clears the accumulator, bit count, flush_pend and byte counter; state is IDLE.
  - Outputs: byte_o=0, store_byte_o=0, stall_cpu_o=0, spr_dat_o=0.
  - A reset during WAIT_ACK drops store_byte_o at that edge; a late ack_i is ignored.
- Accumulator: 40 bits; bit count cnt is 0..38. New bits are appended below the existing valid bits, MSB-first. Bits of bit_vec_i above n-1 are masked off.
- Accept rule: an op is accepted in a cycle with state==IDLE and set_bit_op_i=1.
  - cnt updates to cnt+n at the next edge.
  - n=0 is a no-op.
  - set_bit_op_i outside IDLE is ignored; the CPU is stalled, so the op is held.
- stall_cpu_o = (state != IDLE) | flush_pend. Combinational from registers; no dependency on inputs.
- States:
  - IDLE:
    - Enter EMIT if cnt>=8 after an accept.
    - Else enter FLUSH if flush_pend and cnt>0.
    - Else, if flush_pend and cnt==0, clear flush_pend and stay in IDLE.
  - EMIT: byte_o = top 8 valid bits; assert store_byte_o; go to WAIT_ACK.
  - WAIT_ACK: store_byte_o and byte_o held stable until ack_i=1. On ack:
    - cnt -= 8; byte counter +1.
    - If byte==0xFF and stuffing is enabled, go to STUFF.
    - Else, if cnt>=8, go to EMIT; else go to IDLE.
  - STUFF: byte_o=0x00, store_byte_o=1; wait for ack. On ack, byte counter +1, then take the same exit as WAIT_ACK.
  - FLUSH: pad to 8 bits with PAD_BIT, set cnt=8, go to EMIT. After that byte, flush_pend clears when IDLE is re-entered with cnt==0.
- Handshake timing:
  - store_byte_o deasserts on the edge where ack_i is sampled.
  - There is a minimum of one low cycle between consecutive requests (EMIT is one cycle).
  - ack_i while store_byte_o=0 is ignored.
- SPR map (write requires spr_cs&spr_write; read is combinational on spr_cs):
  - addr 0 write: bit0=1 sets flush_pend. bit1=1 clears the byte counter; the clear wins over a simultaneous increment.
  - addr 0 read: {16'b0, state[3:0], 5'b0, flush_pend, cnt[5:0]}.
  - addr 1 read: byte counter, zero-extended to 32 bits. addr 1 writes are ignored.
  - addr 2 and 3 read 0.
- Simultaneous accept and flush write in IDLE: the op is applied first; the flush stays pending until the op's bytes have been emitted.
- Byte counter wraps modulo 2^CNT_W.

Optional Feature:
- VLX_BYTE_STUFF_EN defined: after every emitted 0xFF byte (including a flush-padded byte), a 0x00 byte is stored via the STUFF state.
- Undefined: STUFF is unreachable and 0xFF is stored without a following 0x00.

Test Plan:
- Ops (0b1010,n=4) then (0xF,n=4), ack after 1 cycle -> one store of byte_o=0xAF; cnt=0; counter=1; stall high from the cycle after the 2nd accept until IDLE.
- With VLX_BYTE_STUFF_EN: op (0xFF,n=8) -> stores 0xFF then 0x00; counter=2. Without the macro -> single store of 0xFF; counter=1.
- Op (0b101,n=3), then SPR write addr0=0x1 -> stall high, store of 0xBF; flush_pend and cnt end at 0.
- cnt=7 (seven 1s), then op (0x7FFFFFFF,n=31) -> 4 stores; cnt=6 afterwards; addr0 read shows cnt=6.
- Ack delayed 5 cycles -> store_byte_o and byte_o unchanged through the wait; a second set_bit_op_i is not accepted until IDLE.
- rst_i low during WAIT_ACK -> at that edge store_byte_o=0, stall_cpu_o=0, counter=0; an ack_i pulse afterwards has no effect.

Source files
------------

// File: rtl/or1200_vlx_seq.sv
`timescale 1ns/1ps
// VLX store-path sequencer: packs variable-length codes MSB-first into a 40-bit accumulator and stores whole bytes.
// Latency: accept -> EMIT next cycle -> store_byte_o the cycle after; one byte in flight, at least one low cycle between requests.
// Backpressure: store waits on ack_i; stall_cpu_o holds the CPU (and its set-bit op) until all bytes and any flush are done.
// Optional: define VLX_BYTE_STUFF_EN to insert a 0x00 byte after every stored 0xFF byte.
module or1200_vlx_seq #(
    parameter logic PAD_BIT = 1'b1,
    parameter int   CNT_W   = 32     // at most 32 so the counter fits the SPR read
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        set_bit_op_i,
    input  logic [4:0]  num_bits_to_write_i,
    input  logic [31:0] bit_vec_i,
    input  logic        ack_i,
    output logic [7:0]  byte_o,
    output logic        store_byte_o,
    output logic        stall_cpu_o,
    input  logic        spr_cs,
    input  logic        spr_write,
    input  logic [1:0]  spr_addr,
    input  logic [31:0] spr_dat_i,
    output logic [31:0] spr_dat_o
);

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_EMIT     = 4'd1;
    localparam logic [3:0] S_WAIT_ACK = 4'd2;
    localparam logic [3:0] S_STUFF    = 4'd3;
    localparam logic [3:0] S_FLUSH    = 4'd4;

`ifdef VLX_BYTE_STUFF_EN
    localparam logic STUFF_EN = 1'b1;
`else
    localparam logic STUFF_EN = 1'b0;
`endif

    logic [3:0]       r_state;
    logic [39:0]      r_acc;        // valid bits are left-aligned at [39 -: r_cnt], rest zero
    logic [5:0]       r_cnt;
    logic             r_flush_pend;
    logic [CNT_W-1:0] r_bcnt;
    logic [7:0]       r_byte;
    logic             r_store;

    logic             w_accept;
    logic [31:0]      w_mask;
    logic [39:0]      w_vec_ext;
    logic [5:0]       w_shift;
    logic [5:0]       w_cnt_nxt;
    logic [39:0]      w_acc_nxt;
    logic [5:0]       w_cnt_sub8;
    logic [7:0]       w_pad_mask;
    logic [7:0]       w_pad_byte;
    logic             w_spr_wr0;
    logic             w_flush_set;
    logic             w_bcnt_clr;
    logic             w_bcnt_inc;
    logic [31:0]      w_bcnt_ext;
    logic [31:0]      w_spr_rd;
    logic             w_unused;

    assign w_accept   = (r_state == S_IDLE) & set_bit_op_i;
    // n==0 yields an all-zero mask, so a zero-length op adds nothing
    assign w_mask     = ~(32'hFFFF_FFFF << num_bits_to_write_i);
    assign w_vec_ext  = {8'b0, bit_vec_i & w_mask};
    // in IDLE r_cnt <= 7 and n <= 31, so the shift is always >= 2
    assign w_shift    = 6'd40 - r_cnt - {1'b0, num_bits_to_write_i};
    assign w_cnt_nxt  = w_accept ? (r_cnt + {1'b0, num_bits_to_write_i}) : r_cnt;
    assign w_acc_nxt  = w_accept ? (r_acc | (w_vec_ext << w_shift)) : r_acc;
    assign w_cnt_sub8 = r_cnt - 6'd8;
    // FLUSH is only entered with 1..7 valid bits
    assign w_pad_mask = 8'hFF >> r_cnt[2:0];
    assign w_pad_byte = PAD_BIT ? (r_acc[39:32] | w_pad_mask) : (r_acc[39:32] & ~w_pad_mask);

    assign w_spr_wr0   = spr_cs & spr_write & (spr_addr == 2'd0);
    assign w_flush_set = w_spr_wr0 & spr_dat_i[0];
    assign w_bcnt_clr  = w_spr_wr0 & spr_dat_i[1];
    // r_store gates ack so that a stray ack outside a request does nothing
    assign w_bcnt_inc  = ack_i & r_store & ((r_state == S_WAIT_ACK) | (r_state == S_STUFF));
    assign w_unused    = &{1'b0, spr_dat_i[31:2]};

    assign byte_o       = r_byte;
    assign store_byte_o = r_store;
    assign stall_cpu_o  = (r_state != S_IDLE) | r_flush_pend;
    assign spr_dat_o    = w_spr_rd;

    // Main sequencer: accept ops, emit bytes, wait for acks, stuff and flush
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state <= S_IDLE;
            r_acc   <= 40'd0;
            r_cnt   <= 6'd0;
            r_byte  <= 8'd0;
            r_store <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_acc <= w_acc_nxt;
                    r_cnt <= w_cnt_nxt;
                    if (w_cnt_nxt >= 6'd8) begin
                        r_state <= S_EMIT;
                    end else if (r_flush_pend && (w_cnt_nxt != 6'd0)) begin
                        r_state <= S_FLUSH;
                    end
                end
                S_EMIT: begin
                    r_byte  <= r_acc[39:32];
                    r_store <= 1'b1;
                    r_state <= S_WAIT_ACK;
                end
                S_WAIT_ACK: begin
                    if (ack_i) begin
                        r_store <= 1'b0;
                        r_acc   <= r_acc << 8;
                        r_cnt   <= w_cnt_sub8;
                        if (STUFF_EN && (r_byte == 8'hFF)) begin
                            r_state <= S_STUFF;
                        end else if (w_cnt_sub8 >= 6'd8) begin
                            r_state <= S_EMIT;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                S_STUFF: begin
                    // first cycle mirrors EMIT so requests keep a low cycle between them
                    if (!r_store) begin
                        r_byte  <= 8'h00;
                        r_store <= 1'b1;
                    end else if (ack_i) begin
                        r_store <= 1'b0;
                        r_state <= (r_cnt >= 6'd8) ? S_EMIT : S_IDLE;
                    end
                end
                S_FLUSH: begin
                    r_acc[39:32] <= w_pad_byte;
                    r_cnt        <= 6'd8;
                    r_state      <= S_EMIT;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Flush request: set by SPR write, retired once IDLE has no bits left
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_flush_pend <= 1'b0;
        end else if (w_flush_set) begin
            r_flush_pend <= 1'b1;
        end else if ((r_state == S_IDLE) && r_flush_pend && (w_cnt_nxt == 6'd0)) begin
            r_flush_pend <= 1'b0;
        end
    end

    // Stored-byte counter: SPR clear beats a same-cycle increment, wraps naturally
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_bcnt <= '0;
        end else if (w_bcnt_clr) begin
            r_bcnt <= '0;
        end else if (w_bcnt_inc) begin
            r_bcnt <= r_bcnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // SPR read mux, zero whenever the chip select is low
    always_comb begin
        w_bcnt_ext = 32'd0;
        w_bcnt_ext[CNT_W-1:0] = r_bcnt;
        w_spr_rd = 32'd0;
        if (spr_cs) begin
            case (spr_addr)
                2'd0:    w_spr_rd = {16'b0, r_state, 5'b0, r_flush_pend, r_cnt};
                2'd1:    w_spr_rd = w_bcnt_ext;
                default: w_spr_rd = 32'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_or1200_vlx_seq.sv
`timescale 1ns/1ps
module tb_or1200_vlx_seq;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        set_bit_op_i;
    logic [4:0]  num_bits_to_write_i;
    logic [31:0] bit_vec_i;
    logic        ack_i;
    logic [7:0]  byte_o;
    logic        store_byte_o;
    logic        stall_cpu_o;
    logic        spr_cs;
    logic        spr_write;
    logic [1:0]  spr_addr;
    logic [31:0] spr_dat_i;
    logic [31:0] spr_dat_o;

`ifdef VLX_BYTE_STUFF_EN
    localparam bit STUFF = 1'b1;
`else
    localparam bit STUFF = 1'b0;
`endif

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  exp_q[$];     // bytes the store unit should see, in order
    bit          mq[$];        // bit-level model of the accumulator
    int unsigned exp_bcnt = 0;
    int          ack_dly = 1;
    bit          resp_en = 1'b0;
    logic [31:0] rd;
    int          c;

    or1200_vlx_seq dut (
        .clk_i(clk_i), .rst_i(rst_i), .set_bit_op_i(set_bit_op_i),
        .num_bits_to_write_i(num_bits_to_write_i), .bit_vec_i(bit_vec_i),
        .ack_i(ack_i), .byte_o(byte_o), .store_byte_o(store_byte_o),
        .stall_cpu_o(stall_cpu_o), .spr_cs(spr_cs), .spr_write(spr_write),
        .spr_addr(spr_addr), .spr_dat_i(spr_dat_i), .spr_dat_o(spr_dat_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_byte(input logic [7:0] b);
        exp_q.push_back(b);
        exp_bcnt++;
        if (STUFF && b == 8'hFF) begin
            exp_q.push_back(8'h00);
            exp_bcnt++;
        end
    endtask

    task automatic model_drain();
        logic [7:0] b;
        while (mq.size() >= 8) begin
            b = 8'h00;
            for (int i = 0; i < 8; i++) b = {b[6:0], mq.pop_front()};
            model_byte(b);
        end
    endtask

    task automatic model_op(input logic [31:0] vec, input int n);
        for (int i = n - 1; i >= 0; i--) mq.push_back(vec[i]);
        model_drain();
    endtask

    task automatic model_flush();
        if (mq.size() > 0) begin
            while (mq.size() < 8) mq.push_back(1'b1);
            model_drain();
        end
    endtask

    // One-cycle set-bit op; garbage is placed above bit n-1 to exercise masking
    task automatic op(input logic [31:0] vec, input int n);
        @(negedge clk_i);
        set_bit_op_i        = 1'b1;
        num_bits_to_write_i = n[4:0];
        bit_vec_i           = vec | ~((32'd1 << n) - 32'd1);
        model_op(vec, n);
        @(negedge clk_i);
        set_bit_op_i = 1'b0;
    endtask

    task automatic spr_rd(input logic [1:0] a, output logic [31:0] d);
        spr_cs = 1'b1; spr_write = 1'b0; spr_addr = a;
        #1 d = spr_dat_o;
        spr_cs = 1'b0;
    endtask

    task automatic spr_wr(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk_i);
        spr_cs = 1'b1; spr_write = 1'b1; spr_addr = a; spr_dat_i = d;
        @(negedge clk_i);
        spr_cs = 1'b0; spr_write = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while ((stall_cpu_o || exp_q.size() != 0) && n < 400) begin
            @(negedge clk_i);
            n++;
        end
        chk({tag, "_done"}, 32'(n < 400), 32'd1);
    endtask

    // Store-unit responder: checks each request against the scoreboard and acks after ack_dly cycles
    initial begin
        logic [7:0] b;
        ack_i = 1'b0;
        forever begin
            @(negedge clk_i);
            if (resp_en && store_byte_o) begin
                b = byte_o;
                for (int k = 0; k < ack_dly; k++) begin
                    @(negedge clk_i);
                    chk("req_hold", {23'd0, store_byte_o, byte_o}, {23'd0, 1'b1, b});
                end
                if (exp_q.size() == 0) chk("extra_store", {24'd0, b}, 32'hFFFF_FFFF);
                else chk("store_byte", {24'd0, b}, {24'd0, exp_q.pop_front()});
                ack_i = 1'b1;
                @(negedge clk_i);
                ack_i = 1'b0;
                chk("req_gap", {31'd0, store_byte_o}, 32'd0);
            end
        end
    end

    initial begin
        rst_i = 1'b0; set_bit_op_i = 1'b0; num_bits_to_write_i = 5'd0; bit_vec_i = 32'd0;
        spr_cs = 1'b0; spr_write = 1'b0; spr_addr = 2'd0; spr_dat_i = 32'd0;
        repeat (3) @(negedge clk_i);
        chk("rst_store", {31'd0, store_byte_o}, 32'd0);
        chk("rst_stall", {31'd0, stall_cpu_o}, 32'd0);
        chk("rst_byte", {24'd0, byte_o}, 32'd0);
        chk("rst_spr_idle", spr_dat_o, 32'd0);
        spr_rd(2'd0, rd); chk("rst_status", rd, 32'd0);
        spr_rd(2'd1, rd); chk("rst_bcnt", rd, 32'd0);
        rst_i = 1'b1;
        resp_en = 1'b1;

        // Two nibbles make 0xAF
        op(32'hA, 4);
        chk("nib1_stall", {31'd0, stall_cpu_o}, 32'd0);
        op(32'hF, 4);
        chk("nib2_stall", {31'd0, stall_cpu_o}, 32'd1);
        wait_idle("nib");
        spr_rd(2'd0, rd); chk("nib_status", rd, 32'd0);
        spr_rd(2'd1, rd); chk("nib_bcnt", rd, exp_bcnt);

        // 0xFF byte, stuffed or not
        op(32'hFF, 8);
        wait_idle("ff");
        spr_rd(2'd1, rd); chk("ff_bcnt", rd, exp_bcnt);

        // Flush 101 -> 0xBF
        op(32'h5, 3);
        spr_wr(2'd0, 32'h1);
        model_flush();
        chk("flush_stall", {31'd0, stall_cpu_o}, 32'd1);
        wait_idle("flush");
        spr_rd(2'd0, rd); chk("flush_status", rd, 32'd0);
        spr_rd(2'd1, rd); chk("flush_bcnt", rd, exp_bcnt);

        // Flush 11 -> padded 0xFF
        op(32'h3, 2);
        spr_wr(2'd0, 32'h1);
        model_flush();
        wait_idle("flushff");
        spr_rd(2'd1, rd); chk("flushff_bcnt", rd, exp_bcnt);

        // n=0 no-op, ignored addr1 write, zero reads on addr 2/3
        op(32'h0, 0);
        spr_rd(2'd0, rd); chk("n0_status", rd, 32'd0);
        spr_wr(2'd1, 32'h1234);
        spr_rd(2'd1, rd); chk("a1wr_bcnt", rd, exp_bcnt);
        spr_rd(2'd2, rd); chk("a2_read", rd, 32'd0);
        spr_rd(2'd3, rd); chk("a3_read", rd, 32'd0);

        // 7 + 31 bits -> 4 bytes, 6 left over
        op(32'h7F, 7);
        spr_rd(2'd0, rd); chk("c7_status", rd, 32'd7);
        op(32'h7FFF_FFFF, 31);
        wait_idle("c38");
        spr_rd(2'd0, rd); chk("c38_status", rd, 32'd6);
        spr_rd(2'd1, rd); chk("c38_bcnt", rd, exp_bcnt);
        spr_wr(2'd0, 32'h1);
        model_flush();
        wait_idle("c38f");

        // Slow ack with a second op held high across the stall
        ack_dly = 5;
        @(negedge clk_i);
        set_bit_op_i = 1'b1; num_bits_to_write_i = 5'd8; bit_vec_i = 32'hA5;
        model_op(32'hA5, 8);
        @(negedge clk_i);
        num_bits_to_write_i = 5'd2; bit_vec_i = 32'hFFFF_FFFF;
        c = 0;
        while (stall_cpu_o && c < 100) begin
            @(negedge clk_i);
            c++;
        end
        chk("hold_done", 32'(c < 100), 32'd1);
        model_op(32'h3, 2);
        @(negedge clk_i);
        set_bit_op_i = 1'b0;
        spr_rd(2'd0, rd); chk("hold_status", rd, 32'd2);
        spr_wr(2'd0, 32'h1);
        model_flush();
        wait_idle("hold");
        spr_rd(2'd1, rd); chk("hold_bcnt", rd, exp_bcnt);
        ack_dly = 1;

        // Counter clear wins over the increment of the same cycle
        resp_en = 1'b0;
        op(32'h12, 8);
        c = 0;
        while (!store_byte_o && c < 20) begin
            @(negedge clk_i);
            c++;
        end
        chk("clr_byte", {24'd0, byte_o}, {24'd0, exp_q.pop_front()});
        ack_i = 1'b1; spr_cs = 1'b1; spr_write = 1'b1; spr_addr = 2'd0; spr_dat_i = 32'h2;
        @(negedge clk_i);
        ack_i = 1'b0; spr_cs = 1'b0; spr_write = 1'b0;
        exp_bcnt = 0;
        chk("clr_store", {31'd0, store_byte_o}, 32'd0);
        spr_rd(2'd1, rd); chk("clr_bcnt", rd, 32'd0);
        wait_idle("clr");

        // Reset while waiting for ack; a late ack is ignored
        op(32'h3C, 8);
        c = 0;
        while (!store_byte_o && c < 20) begin
            @(negedge clk_i);
            c++;
        end
        chk("rstw_byte", {24'd0, byte_o}, {24'd0, exp_q.pop_front()});
        rst_i = 1'b0;
        @(negedge clk_i);
        chk("rstw_store", {31'd0, store_byte_o}, 32'd0);
        chk("rstw_stall", {31'd0, stall_cpu_o}, 32'd0);
        spr_rd(2'd1, rd); chk("rstw_bcnt", rd, 32'd0);
        rst_i = 1'b1;
        mq.delete();
        exp_bcnt = 0;
        ack_i = 1'b1;
        @(negedge clk_i);
        ack_i = 1'b0;
        @(negedge clk_i);
        chk("late_ack_store", {31'd0, store_byte_o}, 32'd0);
        chk("late_ack_stall", {31'd0, stall_cpu_o}, 32'd0);
        spr_rd(2'd0, rd); chk("late_ack_status", rd, 32'd0);
        spr_rd(2'd1, rd); chk("late_ack_bcnt", rd, 32'd0);

        // Normal operation after reset
        resp_en = 1'b1;
        op(32'hC3, 8);
        wait_idle("post");
        spr_rd(2'd1, rd); chk("post_bcnt", rd, exp_bcnt);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
